// File: rtl/adc128s_model_if.sv
// adc128s_model_if: SPI pins between a master and the ADC128S model
interface adc128s_model_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_model.sv
// adc128s_model: oversampled SPI slave model of the ADC128S 8-channel 12-bit A2D
// Optional build macro ADC128S_MISO_TRISTATE_EN floats MISO while deselected.
module adc128s_model (
    input  logic        clk,
    input  logic        rst_n,
    adc128s_model_if.slave spi,
    input  logic [11:0] lft_cell_set,
    input  logic [11:0] rght_cell_set,
    input  logic [11:0] batt_set
);
    logic [2:0]  ss_n_sync_q, ss_n_sync_d;
    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;
    logic [15:0] tx_shft_q, tx_shft_d;
    logic [15:0] rx_shft_q, rx_shft_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  chnl_q, chnl_d;
    logic        armed_q, armed_d;
    logic        ss_low, ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [11:0] chnl_val;
    logic        unused_rx;

    assign ss_low    = ~ss_n_sync_q[1];
    assign ss_fall   = ss_n_sync_q[2] & ~ss_n_sync_q[1];
    assign ss_rise   = ~ss_n_sync_q[2] & ss_n_sync_q[1];
    assign sclk_rise = ~sclk_sync_q[2] & sclk_sync_q[1];
    assign sclk_fall = sclk_sync_q[2] & ~sclk_sync_q[1];
    assign chnl_val  = (chnl_q == 3'd0) ? lft_cell_set :
                       (chnl_q == 3'd4) ? rght_cell_set :
                       (chnl_q == 3'd5) ? batt_set : 12'h000;
    assign unused_rx = ^{rx_shft_q[15:14], rx_shft_q[10:0]};

`ifdef ADC128S_MISO_TRISTATE_EN
    assign spi.MISO = ss_low ? tx_shft_q[15] : 1'bz;
`else
    assign spi.MISO = ss_low ? tx_shft_q[15] : 1'b0;
`endif

    // Next-state: synchronizer shifts, transaction load/shift, channel capture on clean end
    always_comb begin
        ss_n_sync_d = {ss_n_sync_q[1:0], spi.SS_n};
        sclk_sync_d = {sclk_sync_q[1:0], spi.SCLK};
        mosi_sync_d = {mosi_sync_q[0], spi.MOSI};
        tx_shft_d   = tx_shft_q;
        rx_shft_d   = rx_shft_q;
        bit_cnt_d   = bit_cnt_q;
        armed_d     = armed_q;
        chnl_d      = chnl_q;
        if (ss_fall) begin
            tx_shft_d = {4'h0, chnl_val};
            bit_cnt_d = 5'd0;
            armed_d   = 1'b0;
        end else if (ss_low) begin
            if (sclk_rise) begin
                rx_shft_d = {rx_shft_q[14:0], mosi_sync_q[1]};
                bit_cnt_d = (bit_cnt_q == 5'd16) ? bit_cnt_q : bit_cnt_q + 5'd1;
                armed_d   = 1'b1;
            end
            if (sclk_fall && armed_q)
                tx_shft_d = {tx_shft_q[14:0], 1'b0};
        end
        if (ss_rise && bit_cnt_q == 5'd16)
            chnl_d = rx_shft_q[13:11];
    end

    // State registers; reset returns the pins' synchronizers to the idle bus levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_sync_q <= 3'b111;
            sclk_sync_q <= 3'b111;
            mosi_sync_q <= 2'b00;
            tx_shft_q   <= 16'h0000;
            rx_shft_q   <= 16'h0000;
            bit_cnt_q   <= 5'd0;
            chnl_q      <= 3'd0;
            armed_q     <= 1'b0;
        end else begin
            ss_n_sync_q <= ss_n_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            tx_shft_q   <= tx_shft_d;
            rx_shft_q   <= rx_shft_d;
            bit_cnt_q   <= bit_cnt_d;
            chnl_q      <= chnl_d;
            armed_q     <= armed_d;
        end
    end
endmodule

// File: tb/tb_adc128s_model.sv
// tb_adc128s_model: directed SPI transactions against a channel/value model of the ADC128S
module tb_adc128s_model;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] lft_cell_set, rght_cell_set, batt_set;
    int          errors = 0;
    int          checks = 0;
    logic [2:0]  mdl_chnl;
    logic [15:0] exp_word;
    logic        in_xfer = 1'b0;
    int          bit_i = 0;
    int          ss_hi_cnt = 0;
    logic        prev_sclk = 1'b1;
    logic [15:0] got;

`ifdef ADC128S_MISO_TRISTATE_EN
    localparam logic IDLE_MISO = 1'bz;
`else
    localparam logic IDLE_MISO = 1'b0;
`endif

    adc128s_model_if spi ();

    adc128s_model dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi(spi.slave),
        .lft_cell_set(lft_cell_set),
        .rght_cell_set(rght_cell_set),
        .batt_set(batt_set)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] value_of(input logic [2:0] ch);
        if (ch == 3'd0) return lft_cell_set;
        if (ch == 3'd4) return rght_cell_set;
        if (ch == 3'd5) return batt_set;
        return 12'h000;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle compare: each master sample point against the model word, and idle MISO when deselected
    always @(posedge clk) begin
        #1;
        ss_hi_cnt = spi.SS_n ? ss_hi_cnt + 1 : 0;
        if (ss_hi_cnt > 4)
            chk("miso_idle", {15'b0, spi.MISO}, {15'b0, IDLE_MISO});
        if (!in_xfer)
            bit_i = 0;
        else if (spi.SCLK && !prev_sclk && !spi.SS_n) begin
            chk("miso_bit", {15'b0, spi.MISO}, {15'b0, (bit_i < 16) ? exp_word[15 - bit_i] : 1'b0});
            bit_i++;
        end
        prev_sclk = spi.SCLK;
    end

    task automatic xfer(input logic [19:0] cmd, input int nbits, input int chg_bit,
                        input logic [11:0] new_batt, output logic [15:0] rx);
        rx = 16'h0;
        exp_word = {4'h0, value_of(mdl_chnl)};
        in_xfer = 1'b1;
        spi.SS_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) batt_set = new_batt;
            spi.SCLK = 1'b0;
            spi.MOSI = cmd[nbits - 1 - i];
            repeat (8) @(negedge clk);
            spi.SCLK = 1'b1;
            rx = {rx[14:0], spi.MISO};
            repeat (8) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        spi.SS_n = 1'b1;
        in_xfer = 1'b0;
        if (nbits >= 16) mdl_chnl = cmd[13:11];
        repeat (6) @(negedge clk);
    endtask

    initial begin
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        lft_cell_set = 12'h205;
        rght_cell_set = 12'h205;
        batt_set = 12'h0FF;
        mdl_chnl = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_miso", {15'b0, spi.MISO}, {15'b0, IDLE_MISO});
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        xfer(20'h02800, 16, -1, 12'h0, got); chk("t1_reset_chnl0", got, 16'h0205);
        xfer(20'h02000, 16, -1, 12'h0, got); chk("t2_batt", got, 16'h00FF);
        rght_cell_set = 12'h123;
        xfer(20'h01000, 16, -1, 12'h0, got); chk("t3_rght", got, 16'h0123);
        xfer(20'h03800, 16, -1, 12'h0, got); chk("t4_ch2_zero", got, 16'h0000);
        xfer(20'h00000, 16, -1, 12'h0, got); chk("t5_ch7_zero", got, 16'h0000);
        xfer(20'h00028, 8, -1, 12'h0, got);  chk("t6_abort_partial", got, 16'h0002);
        xfer(20'h02800, 16, -1, 12'h0, got); chk("t7_abort_kept_ch0", got, 16'h0205);
        xfer(20'h02800, 16, 6, 12'h800, got); chk("t8_batt_old", got, 16'h00FF);
        xfer(20'hF2000, 20, -1, 12'h0, got); chk("t9_batt_new_long", got, 16'h8000);
        xfer(20'h02800, 16, -1, 12'h0, got); chk("t10_long_sel_ch4", got, 16'h0123);
        lft_cell_set = 12'h7A5;

        spi.SS_n = 1'b0;
        repeat (4) @(negedge clk);
        spi.SCLK = 1'b0;
        spi.MOSI = 1'b1;
        repeat (8) @(negedge clk);
        spi.SCLK = 1'b1;
        repeat (8) @(negedge clk);
        spi.SCLK = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        #1;
        chk("midreset_miso", {15'b0, spi.MISO}, {15'b0, IDLE_MISO});
        mdl_chnl = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        xfer(20'h00000, 16, -1, 12'h0, got); chk("t11_after_reset_ch0", got, 16'h07A5);

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adc128s_model.md
Name: adc128s_model

Overview:
- Behavioural/synthesizable model of the ADC128S 8-channel, 12-bit SPI A2D converter, used as an SPI slave in Segway system simulation.
- Serves left load cell, right load cell and battery readings from bench-controlled inputs.
- Runs on the system clock and oversamples the SPI pins.
- Pipelined like the real part: each 16-bit transaction returns the conversion for the channel requested in the previous transaction.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  SPI slave select, active low.
- SCLK  input  1  SPI serial clock from the master; idle high.
- MOSI  input  1  serial command from the master, MSB first.
- MISO  output  1  serial conversion data to the master, MSB first.
- lft_cell_set  input  12  value returned for channel 0.
- rght_cell_set  input  12  value returned for channel 4.
- batt_set  input  12  value returned for channel 5.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Input synchronization: SS_n, SCLK and MOSI each pass through 2 flops on clk, plus a third flop on SS_n and SCLK for edge detection.
  - SCLK rise/fall and SS_n fall/rise are single-cycle pulses derived from the synchronized signals.
  - MOSI is sampled from its synchronized copy, so it is aligned with the SCLK edge pulses.
- SPI timing:
  - Master changes MOSI on SCLK fall; this block samples MOSI on SCLK rise.
  - This block changes MISO on SCLK fall; the master samples MISO on SCLK rise.
  - Each transaction is 16 SCLK rises while SS_n is low.
- Command word (16 bits, MSB first): bits[13:11] are the channel for the NEXT conversion; all other bits are ignored.
- Channel mapping:
  - 0 → lft_cell_set
  - 4 → rght_cell_set
  - 5 → batt_set
  - 1, 2, 3, 6, 7 → 12'h000
- Registers:
  - tx_shft[15:0]: transmit shift register.
  - rx_shft[15:0]: receive shift register.
  - bit_cnt[4:0]: counts SCLK rises in the current transaction.
  - chnl[2:0]: current channel; reset value 0.
  - armed: set by the first SCLK rise of a transaction.
- SS_n fall:
  - tx_shft ← {4'h0, value(chnl)}, using the set inputs sampled in that clk cycle.
  - bit_cnt ← 0; armed ← 0.
- SCLK rise with SS_n low: rx_shft ← {rx_shft[14:0], MOSI}; bit_cnt increments, saturating at 16; armed ← 1.
- SCLK fall with SS_n low and armed = 1: tx_shft ← {tx_shft[14:0], 1'b0}. A front-porch SCLK fall before the first rise does not shift.
- MISO = tx_shft[15] while SS_n is low.
- SS_n rise:
  - If bit_cnt == 16: chnl ← rx_shft[13:11].
  - Otherwise (aborted transaction): chnl is unchanged and the data is discarded.
  - The next conversion always uses chnl as it stands at the next SS_n fall.
- SCLK edges while SS_n is high are ignored.
- More than 16 SCLK rises: bit_cnt holds at 16; rx keeps shifting, so the last 16 bits received define the channel; tx shifts out zeros.
- Reset (asynchronous) clears all synchronizers to their idle values (SS_n=1, SCLK=1, MOSI=0), tx_shft=0, rx_shft=0, bit_cnt=0, chnl=0, armed=0.
- Reset asserted mid-transaction aborts it; after reset, MISO is at its idle value.
- Changing a set input during a transaction does not affect that transaction; it takes effect at the next SS_n fall.

Optional Feature:
- Macro: ADC128S_MISO_TRISTATE_EN
  - Defined: MISO is high-Z (1'bz) whenever the synchronized SS_n is high, allowing a shared MISO bus.
  - Not defined: MISO is driven 0 while SS_n is high.
- Behaviour while SS_n is low is identical in both builds.

Test Plan:
- Reset with lft=0x205, rght=0x205, batt=0x0FF, then one transaction with command 0x2800 (channel 5) → MISO returns 0x0205 (reset chnl 0); the next transaction returns 0x00FF.
- Command 0x2000 (channel 4) with rght=0x123, followed by any command → second transaction returns 0x0123.
- Command selecting channel 2 → next transaction returns 0x0000.
- SS_n raised after 8 SCLKs while sending channel 5, with prior channel 0 → chnl stays 0; next transaction returns lft_cell_set.
- Change batt_set from 0x0FF to 0x800 mid-transaction on channel 5 → current data 0x00FF; next channel-5 read returns 0x0800.
- SS_n high (macro not defined) → MISO=0; rebuild with ADC128S_MISO_TRISTATE_EN → MISO=z; assert rst_n low mid-transfer → chnl=0 and MISO idle.
